// File: rtl/i2c_master_arbiter_pkg.sv
// Shared types and widths for the I2C master arbiter slice.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY,
    COMPLETE
  } arb_state_t;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

endpackage

// File: rtl/i2c_master_arbiter_if.sv
// Requester-side and master-side handshake bundle for i2c_master_arbiter.
interface i2c_master_arbiter_if
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_rw;
  logic [NUM_REQ*I2C_ADDR_W-1:0] req_addr;
  logic [NUM_REQ*I2C_DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            done;
  logic [NUM_REQ-1:0]            err;
  logic [I2C_DATA_W-1:0]         rdata;
  logic [I2C_ADDR_W-1:0]         m_address;
  logic [I2C_DATA_W-1:0]         m_data_in;
  logic                          m_rw;
  logic                          m_enable;
  logic [I2C_DATA_W-1:0]         m_data_out;
  logic                          m_ready;

  modport master (
    input  req, req_rw, req_addr, req_wdata, m_data_out, m_ready,
    output gnt, done, err, rdata, m_address, m_data_in, m_rw, m_enable
  );

  modport slave (
    output req, req_rw, req_addr, req_wdata, m_data_out, m_ready,
    input  gnt, done, err, rdata, m_address, m_data_in, m_rw, m_enable
  );
endinterface

// File: rtl/i2c_master_arbiter_rr.sv
// Round-robin arbiter: combinational one-hot grant, registered rotating start pointer.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_i,
  input  logic                 update_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] grant_idx_o
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  logic [IW:0]   sum;

  // ptr_q holds the index the search starts at (one past the last winner)
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    sum         = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(i);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      if (!found && req_i[sum[IW-1:0]]) begin
        found                 = 1'b1;
        grant_o[sum[IW-1:0]]  = 1'b1;
        grant_idx_o           = sum[IW-1:0];
      end
    end
    ptr_d = ptr_q;
    if (update_i && found) begin
      ptr_d = (grant_idx_o == IW'(N-1)) ? '0 : grant_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one I2C master controller between NUM_REQ requesters with round-robin
// grant, enable/ready sequencing, timeout abort and read-data return.
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic                  clk,
  input logic                  rst,
  i2c_master_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES+1) > 12) ? $clog2(TIMEOUT_CYCLES+1) : 12;

  arb_state_t             state_q, state_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [I2C_ADDR_W-1:0]  addr_q, addr_d;
  logic [I2C_DATA_W-1:0]  wdata_q, wdata_d;
  logic                   rw_q, rw_d;
  logic [I2C_DATA_W-1:0]  rdata_q, rdata_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_REQ-1:0]     arb_gnt;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_update;
  logic                   timeout;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk         (clk),
    .rst         (rst),
    .req_i       (bus.req),
    .update_i    (arb_update),
    .grant_o     (arb_gnt),
    .grant_idx_o (arb_idx)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rw_d       = rw_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    arb_update = 1'b0;
    timeout    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|bus.req && bus.m_ready) begin
          arb_update = 1'b1;
          gnt_d      = arb_gnt;
          addr_d     = bus.req_addr[arb_idx*I2C_ADDR_W +: I2C_ADDR_W];
          wdata_d    = bus.req_wdata[arb_idx*I2C_DATA_W +: I2C_DATA_W];
          rw_d       = bus.req_rw[arb_idx];
          cnt_d      = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE, BUSY: begin
        // timeout wins over any ready edge seen in the same cycle
        if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          timeout = 1'b1;
          gnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (state_q == ISSUE && !bus.m_ready) begin
            state_d = BUSY;
          end else if (state_q == BUSY && bus.m_ready) begin
            state_d = COMPLETE;
            if (rw_q) rdata_d = bus.m_data_out;
          end
        end
      end
      COMPLETE: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = (state_q == COMPLETE && !rst) ? gnt_q : '0;
  assign bus.err       = (timeout && !rst) ? gnt_q : '0;
  assign bus.m_enable  = (state_q == ISSUE) && !timeout && !rst;
  assign bus.m_address = addr_q;
  assign bus.m_data_in = wdata_q;
  assign bus.m_rw      = rw_q;
  assign bus.rdata     = rdata_q;
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Self-checking bench for i2c_master_arbiter: directed scenarios plus random
// request mixes against a round-robin / memory reference model.
module tb_i2c_master_arbiter;
  import i2c_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int TMO     = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i2c_master_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  i2c_master_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  bit started = 1'b0;
  bit stuck = 1'b0;
  int busy_min = 1;

  logic [7:0]  slave_mem [128];
  logic [7:0]  ref_mem   [128];
  logic [15:0] log_q [$];
  logic        t_rw    [NUM_REQ];
  logic [6:0]  t_addr  [NUM_REQ];
  logic [7:0]  t_wdata [NUM_REQ];
  int          rr_start = 0;
  logic [7:0]  exp_rdata = 8'h00;
  logic [NUM_REQ-1:0] prev_done = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Structural invariants, sampled on the falling edge
  always @(negedge clk) begin
    if (started && !rst) begin
      checks++;
      assert ($onehot0(bus.gnt) && !(|bus.done && |bus.err) && !(|(bus.done & prev_done))) else begin
        errors++;
        $error("FAIL invariant gnt=%b done=%b err=%b prev_done=%b", bus.gnt, bus.done, bus.err, prev_done);
      end
      if (|bus.done) done_cnt++;
      if (|bus.err)  err_cnt++;
      prev_done = bus.done;
    end
  end

  // Behavioural I2C master controller: accepts on enable, goes busy, returns ready
  logic [6:0] la;
  logic       lrw;
  logic [7:0] ld;
  initial begin
    bus.m_ready    = 1'b1;
    bus.m_data_out = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.m_enable === 1'b1 && bus.m_ready) begin
        la  = bus.m_address;
        lrw = bus.m_rw;
        ld  = bus.m_data_in;
        log_q.push_back({lrw, la, ld});
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.m_ready = 1'b0;
        if (stuck) begin
          while (stuck) @(negedge clk);
        end else begin
          repeat ($urandom_range(busy_min, busy_min + 4)) @(negedge clk);
          if (lrw) bus.m_data_out = slave_mem[la];
          else begin
            slave_mem[la]  = ld;
            bus.m_data_out = 8'($urandom);
          end
        end
        bus.m_ready = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int pick(input logic [NUM_REQ-1:0] m);
    for (int k = 0; k < NUM_REQ; k++)
      if (m[(rr_start + k) % NUM_REQ]) return (rr_start + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic rw, input logic [6:0] a, input logic [7:0] d);
    t_rw[i]    = rw;
    t_addr[i]  = a;
    t_wdata[i] = d;
    bus.req_rw[i]         = rw;
    bus.req_addr[i*7 +: 7]  = a;
    bus.req_wdata[i*8 +: 8] = d;
    bus.req[i]            = 1'b1;
  endtask

  task automatic set_rand_req(input int i);
    set_req(i, 1'($urandom), 7'($urandom), 8'($urandom));
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    while (bus.gnt === '0 && n < 50) begin @(negedge clk); n++; end
  endtask

  // Waits for requester exp_i to finish and checks everything the model predicts
  task automatic expect_txn(input int exp_i, input string tag);
    int n;
    logic [NUM_REQ-1:0] d, e;
    logic [15:0] ent;
    n = 0;
    while (bus.done === '0 && bus.err === '0 && n < 300) begin @(negedge clk); n++; end
    d = bus.done;
    e = bus.err;
    check({tag, "_done"}, d, 32'(1 << exp_i));
    check({tag, "_err"}, e, 0);
    check({tag, "_lognum"}, log_q.size(), 1);
    if (log_q.size() > 0) begin
      ent = log_q.pop_front();
      check({tag, "_xfer"}, ent, {t_rw[exp_i], t_addr[exp_i], t_wdata[exp_i]});
    end
    if (t_rw[exp_i]) exp_rdata = ref_mem[t_addr[exp_i]];
    else ref_mem[t_addr[exp_i]] = t_wdata[exp_i];
    check({tag, "_rdata"}, bus.rdata, exp_rdata);
    bus.req[exp_i] = 1'b0;
    rr_start = (exp_i + 1) % NUM_REQ;
    @(negedge clk);
    check({tag, "_gap_gnt"}, bus.gnt, 0);
    check({tag, "_done_pulse"}, bus.done, 0);
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    rr_start  = 0;
    exp_rdata = 8'h00;
    log_q.delete();
  endtask

  initial begin
    int n, t_g, t_e, w, k, dc, ec, guard;
    logic [NUM_REQ-1:0] m;
    rst           = 1'b1;
    bus.req       = '0;
    bus.req_rw    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int a = 0; a < 128; a++) begin
      slave_mem[a] = 8'($urandom);
      ref_mem[a]   = slave_mem[a];
    end
    repeat (3) @(negedge clk);

    check("rst_gnt", bus.gnt, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_en", bus.m_enable, 0);
    check("rst_rw", bus.m_rw, 0);
    check("rst_addr", bus.m_address, 0);
    check("rst_wdata", bus.m_data_in, 0);
    check("rst_rdata", bus.rdata, 0);
    rst = 1'b0;
    started = 1'b1;
    @(negedge clk);
    check("idle_gnt", bus.gnt, 0);
    check("idle_en", bus.m_enable, 0);

    // Single write
    set_req(0, 1'b0, 7'h2A, 8'hA5);
    w = pick(bus.req);
    @(negedge clk);
    check("wr_gnt_latency", bus.gnt, 32'h1);
    expect_txn(w, "wr0");
    check("wr0_slave_mem", slave_mem[7'h2A], 8'hA5);

    // Single read
    slave_mem[7'h1D] = 8'h99;
    ref_mem[7'h1D]   = 8'h99;
    set_req(2, 1'b1, 7'h1D, 8'h00);
    expect_txn(pick(bus.req), "rd2");
    check("rd2_value", bus.rdata, 8'h99);

    // Contention from a fresh pointer, then wrap
    apply_reset(2);
    for (int i = 0; i < NUM_REQ; i++) set_rand_req(i);
    for (int i = 0; i < NUM_REQ; i++) expect_txn(pick(bus.req), "cont");
    set_rand_req(0);
    set_rand_req(3);
    expect_txn(pick(bus.req), "wrap");
    expect_txn(pick(bus.req), "wrap2");

    // Timeout with master stuck busy
    stuck = 1'b1;
    set_req(1, 1'b1, 7'h11, 8'h5A);
    wait_gnt(n);
    t_g = cyc;
    check("tmo_gnt", bus.gnt, 32'h2);
    n = 0;
    while (bus.err === '0 && bus.done === '0 && n < 200) begin @(negedge clk); n++; end
    t_e = cyc;
    check("tmo_err", bus.err, 32'h2);
    check("tmo_no_done", bus.done, 0);
    check("tmo_latency", t_e - t_g, TMO);
    check("tmo_en_low", bus.m_enable, 0);
    check("tmo_rdata_kept", bus.rdata, exp_rdata);
    bus.req[1] = 1'b0;
    rr_start = 2;
    @(negedge clk);
    check("tmo_gnt_clear", bus.gnt, 0);
    stuck = 1'b0;
    repeat (2) @(negedge clk);
    log_q.delete();
    set_rand_req(2);
    expect_txn(pick(bus.req), "after_tmo");

    // Requester inputs change after grant
    set_req(0, 1'b0, 7'h33, 8'h3C);
    wait_gnt(n);
    @(negedge clk);
    bus.req_wdata[7:0] = 8'hFF;
    @(negedge clk);
    check("chg_data_in", bus.m_data_in, 8'h3C);
    expect_txn(0, "chg");
    check("chg_slave_mem", slave_mem[7'h33], 8'h3C);

    // Reset while the master is busy
    busy_min = 8;
    set_req(3, 1'b1, 7'h44, 8'h00);
    n = 0;
    while (!(bus.gnt !== '0 && bus.m_ready === 1'b0 && bus.m_enable === 1'b0) && n < 50) begin
      @(negedge clk); n++;
    end
    check("rstb_in_busy", bus.gnt, 32'h8);
    dc = done_cnt;
    ec = err_cnt;
    rst = 1'b1;
    check("rstb_en_now", bus.m_enable, 0);
    @(negedge clk);
    check("rstb_gnt", bus.gnt, 0);
    check("rstb_done", bus.done, 0);
    check("rstb_err", bus.err, 0);
    rst = 1'b0;
    bus.req[3] = 1'b0;
    rr_start  = 0;
    exp_rdata = 8'h00;
    log_q.delete();
    n = 0;
    while (bus.m_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check("rstb_no_done", done_cnt, dc);
    check("rstb_no_err", err_cnt, ec);
    check("rstb_rdata", bus.rdata, 0);
    busy_min = 1;
    set_req(1, 1'b1, 7'h55, 8'h00);
    expect_txn(pick(bus.req), "rstb_next");

    // Random request mixes, with occasional late arrivals
    for (int r = 0; r < 25; r++) begin
      m = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      for (int i = 0; i < NUM_REQ; i++) if (m[i]) set_rand_req(i);
      guard = 0;
      while (bus.req != '0 && guard < 40) begin
        expect_txn(pick(bus.req), "rnd");
        if ($urandom_range(0, 3) == 0) begin
          k = $urandom_range(0, NUM_REQ - 1);
          if (!bus.req[k]) set_rand_req(k);
        end
        guard++;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
